c1541_gcr_head: RTL and testbench

- Drive-mechanics/GCR bit-stream stage directly downstream of the 1541 logic board's disk port.
- Emulates the read/write head over one track of GCR bytes held in an external synchronous track buffer.
- Produces din, sync_n and byte_n for the logic board; consumes dout, mode, soe, mtr and speed_zone from it.
- Bit cells are timed from clk32 per density zone.

---
 rtl/c1541_pkg.sv | 19 +
 rtl/c1541_bitclk.sv | 31 +++
 rtl/c1541_gcr_head.sv | 156 +++++++++++++++
 tb/tb_c1541_gcr_head.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/c1541_pkg.sv
// Shared constants and helpers for the 1541 GCR head emulation.
// Optional write-protect gating is enabled with the C1541_WPROT_EN macro.
package c1541_pkg;
    localparam int BITCELL_BASE     = 16;
    localparam int CLK_PER_CELL_DIV = 8;
    localparam int SYNC_ONES        = 10;
    localparam int DEF_ADDR_W       = 13;
    localparam int PER_W            = 8;

    typedef enum logic {
        HEAD_WRITE = 1'b0,
        HEAD_READ  = 1'b1
    } head_mode_e;

    // clk32 cycles per bit cell for a density zone: 128, 120, 112, 104
    function automatic logic [PER_W-1:0] bit_period(input logic [1:0] zone);
        return PER_W'(CLK_PER_CELL_DIV * (BITCELL_BASE - int'(zone)));
    endfunction
endpackage

// File: rtl/c1541_bitclk.sv
// Zone-programmable bit-cell timer; one-cycle tick per cell, frozen while run=0.
module c1541_bitclk
    import c1541_pkg::*;
(
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       run,
    input  logic [1:0] speed_zone,
    output logic       tick
);
    localparam logic [PER_W-1:0] ONE = PER_W'(1);

    logic [PER_W-1:0] cnt_q, cnt_d;

    // Reload with period-1 so consecutive ticks are exactly one period apart
    always_comb begin
        cnt_d = cnt_q;
        if (run) begin
            if (cnt_q == '0) cnt_d = bit_period(speed_zone) - ONE;
            else             cnt_d = cnt_q - ONE;
        end
    end

    // Zone is unknown in reset, so the first cell after reset uses zone 0
    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) cnt_q <= bit_period(2'd0) - ONE;
        else          cnt_q <= cnt_d;
    end

    assign tick = run && (cnt_q == '0);
endmodule

// File: rtl/c1541_gcr_head.sv
// Read/write head over one GCR track held in an external synchronous buffer.
// Define C1541_WPROT_EN to suppress buffer writes while wps_n=0.
module c1541_gcr_head
    import c1541_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BYTE_N_LEN = 16
) (
    input  logic              clk32,
    input  logic              reset_n,
    input  logic              mtr,
    input  logic              mode,
    input  logic              soe,
    input  logic [1:0]        speed_zone,
    input  logic [7:0]        dout,
    input  logic              wps_n,
    input  logic [ADDR_W-1:0] track_len,
    output logic [7:0]        din,
    output logic              sync_n,
    output logic              byte_n,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [7:0]        buf_rdata,
    output logic [7:0]        buf_wdata,
    output logic              buf_we
);
    localparam logic [6:0] BN_LEN = 7'(BYTE_N_LEN);

    logic run, tick, we_allow, byte_done, head_bit, no_disk;
    logic [ADDR_W:0] nxt_addr;

    logic [7:0]        hd_sr_q, hd_sr_d, wa_q, wa_d, rx_sr_q, rx_sr_d, tx_sr_q, tx_sr_d;
    logic [7:0]        din_q, din_d, buf_wdata_q, buf_wdata_d;
    logic [2:0]        hd_bit_q, hd_bit_d, bit_cnt_q, bit_cnt_d, vld_pipe_q, vld_pipe_d;
    logic [1:0]        init_q, init_d;
    logic [3:0]        ones_q, ones_d;
    logic [6:0]        bn_cnt_q, bn_cnt_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic              mode_prev_q, mode_prev_d, sync_n_q, sync_n_d, byte_n_q, byte_n_d;
    logic              buf_we_q, buf_we_d;

    assign no_disk = (track_len == '0);
    assign run     = mtr && !no_disk;

`ifdef C1541_WPROT_EN
    assign we_allow = wps_n;
`else
    logic wps_unused;
    assign wps_unused = wps_n;
    assign we_allow   = 1'b1;
`endif

    c1541_bitclk u_bitclk (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .run        (run),
        .speed_zone (speed_zone),
        .tick       (tick)
    );

    always_comb begin
        hd_sr_d = hd_sr_q;  wa_d = wa_q;  rx_sr_d = rx_sr_q;  tx_sr_d = tx_sr_q;
        din_d = din_q;  hd_bit_d = hd_bit_q;  bit_cnt_d = bit_cnt_q;  ones_d = ones_q;
        bn_cnt_d = bn_cnt_q;  cur_d = cur_q;  mode_prev_d = mode_prev_q;  sync_n_d = sync_n_q;
        buf_wdata_d = buf_wdata_q;
        buf_we_d  = 1'b0;
        byte_done = 1'b0;
        head_bit  = hd_sr_q[7];
        // vld_pipe: [0]=T+1 (write), [1]=T+2 (advance), [2]=T+3 (reload)
        vld_pipe_d = {vld_pipe_q[1:0], tick && (hd_bit_q == 3'd7)};
        init_d     = {init_q[0], 1'b0};
        nxt_addr   = {1'b0, cur_q} + {{ADDR_W{1'b0}}, 1'b1};

        if (run && bn_cnt_q != '0) bn_cnt_d = bn_cnt_q - 7'd1;

        if (tick) begin
            hd_sr_d     = {hd_sr_q[6:0], 1'b0};
            hd_bit_d    = hd_bit_q + 3'd1;
            mode_prev_d = mode;
            wa_d[3'd7 - hd_bit_q] = head_bit;
            if (mode == HEAD_READ) begin
                ones_d = head_bit ? ((ones_q == 4'hF) ? ones_q : ones_q + 4'd1) : 4'd0;
                if (ones_d >= 4'(SYNC_ONES)) begin
                    sync_n_d  = 1'b0;
                    bit_cnt_d = 3'd0;
                end else begin
                    sync_n_d  = 1'b1;
                    rx_sr_d   = {rx_sr_q[6:0], head_bit};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        din_d     = rx_sr_d;
                        byte_done = 1'b1;
                    end
                end
            end else begin
                sync_n_d = 1'b1;
                ones_d   = 4'd0;
                // First write-mode cell only primes the shifter from dout
                if (mode_prev_q == HEAD_READ) begin
                    tx_sr_d   = dout;
                    bit_cnt_d = 3'd0;
                end else begin
                    wa_d[3'd7 - hd_bit_q] = tx_sr_q[7];
                    tx_sr_d   = {tx_sr_q[6:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        tx_sr_d   = dout;
                        byte_done = 1'b1;
                    end
                end
                if (hd_bit_q == 3'd7) begin
                    buf_we_d    = we_allow;
                    buf_wdata_d = wa_d;
                end
            end
            if (byte_done && soe) bn_cnt_d = BN_LEN;
        end

        if (vld_pipe_q[0]) cur_d = (nxt_addr >= {1'b0, track_len}) ? '0 : nxt_addr[ADDR_W-1:0];
        if (vld_pipe_q[2] || init_q[1]) hd_sr_d = buf_rdata;

        if (no_disk) sync_n_d = 1'b1;
        byte_n_d = (bn_cnt_d == '0) || !sync_n_d || no_disk;
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            hd_sr_q <= '0;  wa_q <= '0;  rx_sr_q <= '0;  tx_sr_q <= '0;  din_q <= '0;
            hd_bit_q <= '0;  bit_cnt_q <= '0;  ones_q <= '0;  bn_cnt_q <= '0;  cur_q <= '0;
            vld_pipe_q  <= '0;
            init_q      <= 2'b01;
            mode_prev_q <= HEAD_READ;
            sync_n_q    <= 1'b1;
            byte_n_q    <= 1'b1;
            buf_we_q    <= 1'b0;
            buf_wdata_q <= '0;
        end else begin
            hd_sr_q <= hd_sr_d;  wa_q <= wa_d;  rx_sr_q <= rx_sr_d;  tx_sr_q <= tx_sr_d;  din_q <= din_d;
            hd_bit_q <= hd_bit_d;  bit_cnt_q <= bit_cnt_d;  ones_q <= ones_d;  bn_cnt_q <= bn_cnt_d;
            cur_q <= cur_d;
            vld_pipe_q  <= vld_pipe_d;
            init_q      <= init_d;
            mode_prev_q <= mode_prev_d;
            sync_n_q    <= sync_n_d;
            byte_n_q    <= byte_n_d;
            buf_we_q    <= buf_we_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end

    assign din       = din_q;
    assign sync_n    = sync_n_q;
    assign byte_n    = byte_n_q;
    assign buf_addr  = cur_q;
    assign buf_we    = buf_we_q;
    assign buf_wdata = buf_wdata_q;
endmodule

// File: tb/tb_c1541_gcr_head.sv
// Scoreboard bench for c1541_gcr_head with a behavioural synchronous track buffer.
module tb_c1541_gcr_head;
    localparam int ADDR_W = 13;
    localparam int BYTE_N_LEN = 16;

    logic clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    logic reset_n, mtr, mode, soe, wps_n, sync_n, byte_n, buf_we;
    logic [1:0] speed_zone;
    logic [7:0] dout, din, buf_rdata, buf_wdata;
    logic [ADDR_W-1:0] track_len, buf_addr;

    logic tb_we;
    logic [ADDR_W-1:0] tb_addr;
    logic [7:0] tb_data;
    logic [7:0] mem [0:(1<<ADDR_W)-1];
    int cyc = 0;
    int chk_cnt = 0;
    int pass_cnt = 0;
    logic [7:0] exp_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    c1541_gcr_head #(.ADDR_W(ADDR_W), .BYTE_N_LEN(BYTE_N_LEN)) dut (
        .clk32(clk32), .reset_n(reset_n), .mtr(mtr), .mode(mode), .soe(soe),
        .speed_zone(speed_zone), .dout(dout), .wps_n(wps_n), .track_len(track_len),
        .din(din), .sync_n(sync_n), .byte_n(byte_n), .buf_addr(buf_addr),
        .buf_rdata(buf_rdata), .buf_wdata(buf_wdata), .buf_we(buf_we)
    );

    always @(posedge clk32) begin
        cyc <= cyc + 1;
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (buf_we) mem[buf_addr] <= buf_wdata;
        buf_rdata <= mem[buf_addr];
    end

    // trk = {byte0, byte1, byte2, byte3}
    task automatic do_reset(input logic [1:0] z, input logic m, input logic [ADDR_W-1:0] len,
                            input logic [3:0][7:0] trk);
        @(negedge clk32);
        reset_n = 0; mtr = 1; mode = m; soe = 1; wps_n = 1; dout = 8'h55;
        speed_zone = z; track_len = len;
        for (int i = 0; i < 4; i++) begin
            tb_we = 1; tb_addr = ADDR_W'(i); tb_data = trk[3-i];
            @(negedge clk32);
        end
        tb_we = 0;
        @(negedge clk32);
        reset_n = 1;
    endtask

    task automatic test_reset();
        do_reset(2'd3, 1'b1, 4, {8'hFF, 8'hFF, 8'h52, 8'h54});
        repeat (1000) @(negedge clk32);
        chk_cnt++; if (din !== 8'hFF) $display("FAIL reset_pre_din got %h want ff", din); else pass_cnt++;
        reset_n = 0; #1;
        chk_cnt++; if (din !== 8'h00) $display("FAIL reset_din got %h want 00", din); else pass_cnt++;
        chk_cnt++; if (sync_n !== 1'b1) $display("FAIL reset_sync_n got %b want 1", sync_n); else pass_cnt++;
        chk_cnt++; if (byte_n !== 1'b1) $display("FAIL reset_byte_n got %b want 1", byte_n); else pass_cnt++;
        chk_cnt++; if (buf_we !== 1'b0) $display("FAIL reset_buf_we got %b want 0", buf_we); else pass_cnt++;
        chk_cnt++; if (buf_addr !== '0) $display("FAIL reset_buf_addr got %0d want 0", buf_addr); else pass_cnt++;
        @(negedge clk32); reset_n = 1; @(negedge clk32);
        chk_cnt++; if (buf_addr !== '0) $display("FAIL reset_rel_addr got %0d want 0", buf_addr); else pass_cnt++;
        chk_cnt++; if (din !== 8'h00) $display("FAIL reset_rel_din got %h want 00", din); else pass_cnt++;
    endtask

    task automatic test_sync_read();
        int t_sf = -1, t_sr = -1, t_bf = 0, lows = 0, viol = 0;
        bit seen52 = 0;
        logic ps, pb;
        logic [7:0] e;
        exp_q.delete();
        exp_q.push_back(8'hFF); exp_q.push_back(8'h52); exp_q.push_back(8'h54);
        exp_q.push_back(8'hFF); exp_q.push_back(8'h52); exp_q.push_back(8'h54);
        do_reset(2'd3, 1'b1, 4, {8'hFF, 8'hFF, 8'h52, 8'h54});
        ps = sync_n; pb = byte_n;
        for (int c = 0; c < 7000 && exp_q.size() > 0; c++) begin
            @(negedge clk32);
            if (!sync_n && !byte_n) viol++;
            if (ps && !sync_n && t_sf < 0) t_sf = cyc;
            if (!ps && sync_n && t_sr < 0) t_sr = cyc;
            if (pb && !byte_n) begin
                e = exp_q.pop_front();
                t_bf = cyc;
                chk_cnt++; if (din !== e) $display("FAIL read_din got %h want %h", din, e); else pass_cnt++;
                if (e == 8'h52 && !seen52) begin
                    seen52 = 1;
                    chk_cnt++;
                    if (t_bf - t_sr !== 728) $display("FAIL read_52_delay got %0d want 728", t_bf - t_sr);
                    else pass_cnt++;
                end
            end
            if (!pb && byte_n && lows < 2) begin
                lows++;
                chk_cnt++;
                if (cyc - t_bf !== BYTE_N_LEN) $display("FAIL byte_n_len got %0d want %0d", cyc - t_bf, BYTE_N_LEN);
                else pass_cnt++;
            end
            ps = sync_n; pb = byte_n;
        end
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL read_timeout left %0d want 0", exp_q.size()); else pass_cnt++;
        chk_cnt++; if (t_sr - t_sf !== 728) $display("FAIL sync_len got %0d want 728", t_sr - t_sf); else pass_cnt++;
        chk_cnt++; if (viol != 0) $display("FAIL byte_n_in_sync got %0d want 0", viol); else pass_cnt++;
    endtask

    task automatic test_zone();
        for (int k = 0; k < 2; k++) begin
            int t1 = 0, t2 = 0, n = 0, want;
            logic pb;
            logic [7:0] e;
            want = (k == 0) ? 1024 : 832;
            exp_q.delete();
            exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
            do_reset((k == 0) ? 2'd0 : 2'd3, 1'b1, 4, {8'h55, 8'hAA, 8'h55, 8'hAA});
            pb = byte_n;
            for (int c = 0; c < 3500 && exp_q.size() > 0; c++) begin
                @(negedge clk32);
                if (pb && !byte_n) begin
                    e = exp_q.pop_front();
                    n++;
                    if (n == 1) t1 = cyc; else t2 = cyc;
                    chk_cnt++; if (din !== e) $display("FAIL zone_din got %h want %h", din, e); else pass_cnt++;
                end
                pb = byte_n;
            end
            chk_cnt++; if (exp_q.size() != 0) $display("FAIL zone_timeout left %0d want 0", exp_q.size()); else pass_cnt++;
            chk_cnt++; if (t2 - t1 !== want) $display("FAIL zone_spacing got %0d want %0d", t2 - t1, want); else pass_cnt++;
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] pa, e;
        addr_q.delete();
        addr_q.push_back(1); addr_q.push_back(2); addr_q.push_back(0); addr_q.push_back(1);
        do_reset(2'd3, 1'b1, 3, {8'h11, 8'h22, 8'h33, 8'h00});
        chk_cnt++; if (buf_addr !== '0) $display("FAIL wrap_start got %0d want 0", buf_addr); else pass_cnt++;
        pa = buf_addr;
        for (int c = 0; c < 4000 && addr_q.size() > 0; c++) begin
            @(negedge clk32);
            if (buf_addr !== pa) begin
                e = addr_q.pop_front();
                chk_cnt++; if (buf_addr !== e) $display("FAIL wrap_addr got %0d want %0d", buf_addr, e); else pass_cnt++;
            end
            pa = buf_addr;
        end
        chk_cnt++; if (addr_q.size() != 0) $display("FAIL wrap_timeout left %0d want 0", addr_q.size()); else pass_cnt++;
    endtask

    task automatic test_write();
        int tp = -1;
        logic [ADDR_W-1:0] e;
        addr_q.delete();
        for (int i = 0; i < 5; i++) addr_q.push_back(ADDR_W'(i % 4));
        do_reset(2'd3, 1'b0, 4, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        for (int c = 0; c < 5000 && addr_q.size() > 0; c++) begin
            @(negedge clk32);
            if (buf_we) begin
                e = addr_q.pop_front();
                chk_cnt++; if (buf_addr !== e) $display("FAIL wr_addr got %0d want %0d", buf_addr, e); else pass_cnt++;
                chk_cnt++; if (buf_wdata !== 8'hAA) $display("FAIL wr_data got %h want aa", buf_wdata); else pass_cnt++;
                if (tp >= 0) begin
                    chk_cnt++; if (cyc - tp !== 832) $display("FAIL wr_spacing got %0d want 832", cyc - tp); else pass_cnt++;
                end
                tp = cyc;
            end
        end
        chk_cnt++; if (addr_q.size() != 0) $display("FAIL wr_timeout left %0d want 0", addr_q.size()); else pass_cnt++;
        repeat (4) @(negedge clk32);
        for (int i = 0; i < 4; i++) begin
            chk_cnt++; if (mem[i] !== 8'hAA) $display("FAIL wr_mem[%0d] got %h want aa", i, mem[i]); else pass_cnt++;
        end
    endtask

    task automatic test_wprot();
        int we_cnt = 0, bf_cnt = 0, want_we;
        logic pb;
`ifdef C1541_WPROT_EN
        want_we = 0;
`else
        want_we = 5;
`endif
        do_reset(2'd3, 1'b0, 4, {8'hFF, 8'hFF, 8'hFF, 8'hFF});
        wps_n = 0;
        pb = byte_n;
        repeat (4400) begin
            @(negedge clk32);
            if (buf_we) we_cnt++;
            if (pb && !byte_n) bf_cnt++;
            pb = byte_n;
        end
        chk_cnt++; if (we_cnt != want_we) $display("FAIL wprot_we got %0d want %0d", we_cnt, want_we); else pass_cnt++;
        chk_cnt++; if (bf_cnt != 5) $display("FAIL wprot_byte_n got %0d want 5", bf_cnt); else pass_cnt++;
    endtask

    task automatic test_motor();
        int t1 = -1, t2 = -1, viol = 0;
        logic pb;
        logic [7:0] e;
        logic [ADDR_W-1:0] a0;
        exp_q.delete();
        exp_q.push_back(8'h55); exp_q.push_back(8'hAA);
        do_reset(2'd3, 1'b1, 4, {8'h55, 8'hAA, 8'h55, 8'hAA});
        pb = byte_n;
        for (int c = 0; c < 2000 && t1 < 0; c++) begin
            @(negedge clk32);
            if (pb && !byte_n) t1 = cyc;
            pb = byte_n;
        end
        e = exp_q.pop_front();
        chk_cnt++; if (din !== e) $display("FAIL motor_first got %h want %h", din, e); else pass_cnt++;
        repeat (250) @(posedge clk32);
        #1 mtr = 0;
        a0 = buf_addr;
        repeat (500) begin
            @(negedge clk32);
            if (!byte_n || buf_addr !== a0) viol++;
        end
        @(posedge clk32);
        #1 mtr = 1;
        chk_cnt++; if (viol != 0) $display("FAIL motor_frozen got %0d want 0", viol); else pass_cnt++;
        pb = byte_n;
        for (int c = 0; c < 2000 && t2 < 0; c++) begin
            @(negedge clk32);
            if (pb && !byte_n) t2 = cyc;
            pb = byte_n;
        end
        e = exp_q.pop_front();
        chk_cnt++; if (din !== e) $display("FAIL motor_byte got %h want %h", din, e); else pass_cnt++;
        chk_cnt++; if (t2 - t1 !== 1332) $display("FAIL motor_spacing got %0d want 1332", t2 - t1); else pass_cnt++;
    endtask

    initial begin
        reset_n = 0; mtr = 0; mode = 1; soe = 1; wps_n = 1; speed_zone = 0;
        dout = 0; track_len = 0; tb_we = 0; tb_addr = 0; tb_data = 0;
        test_reset();
        test_sync_read();
        test_zone();
        test_wrap();
        test_write();
        test_wprot();
        test_motor();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
